sm_reg_snapshot: RTL and testbench

Frame-coherent responder between the CPU register debug port and the VGA debug screen. On each frame-start pulse it scans all CPU registers through the CPU's `regAddr`/`regData` read port into a shadow buffer. The screen's `regAddr` requests are then served from that buffer, so a displayed frame never mixes register values from different CPU cycles. It sits in `sm_top` between `sm_cpu` and `vga_debug_screen`, clocked by `clkIn`.

---
 rtl/sm_snapshot_pkg.sv | 14 +
 rtl/sm_snapshot_ram.sv | 28 ++
 rtl/sm_reg_snapshot.sv | 102 ++++++++++
 tb/tb_sm_reg_snapshot.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sm_snapshot_pkg.sv
// Shared types and default sizes for the frame-coherent register snapshot block.
// Build option: SM_SNAPSHOT_DBLBUF_EN selects a double-buffered shadow store.
package sm_snapshot_pkg;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_SCAN = 1'b1
  } snap_state_e;

  localparam int SNAP_REG_CNT = 32;
  localparam int SNAP_ADDR_W  = 5;
  localparam int SNAP_DATA_W  = 32;

endpackage

// File: rtl/sm_snapshot_ram.sv
// Simple dual-port shadow RAM: one synchronous write port, one registered read port.
// The read register can be forced to zero so masked/reset output needs no extra stage.
module sm_snapshot_ram #(
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rd_clr) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/sm_reg_snapshot.sv
// Scans all CPU registers into a shadow store on each frame start and serves the screen from it.
// Build option: SM_SNAPSHOT_DBLBUF_EN adds a back bank swapped atomically when a scan completes.
module sm_reg_snapshot
  import sm_snapshot_pkg::*;
#(
  parameter int REG_CNT = SNAP_REG_CNT,
  parameter int ADDR_W  = SNAP_ADDR_W,
  parameter int DATA_W  = SNAP_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic [ADDR_W-1:0] scr_addr,
  output logic [DATA_W-1:0] scr_data,
  output logic              busy,
  output logic              snap_valid,
  output logic              overrun
);

`ifdef SM_SNAPSHOT_DBLBUF_EN
  localparam int RAM_AW = ADDR_W + 1;
  logic bank_sel;
`else
  localparam int RAM_AW = ADDR_W;
`endif

  snap_state_e       state;
  logic [ADDR_W-1:0] k;
  logic              last;
  logic              we;
  logic [RAM_AW-1:0] waddr;
  logic [RAM_AW-1:0] raddr;

  // The scan counter doubles as the CPU read address; it rests at 0 while idle.
  assign cpu_addr = k;
  assign last     = (k == ADDR_W'(REG_CNT - 1));
  assign we       = (state == SNAP_SCAN) && !rst;

`ifdef SM_SNAPSHOT_DBLBUF_EN
  assign waddr = {~bank_sel, k};
  assign raddr = {bank_sel, scr_addr};
`else
  assign waddr = k;
  assign raddr = scr_addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SNAP_IDLE;
      k          <= '0;
      busy       <= 1'b0;
      snap_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SM_SNAPSHOT_DBLBUF_EN
      bank_sel   <= 1'b0;
`endif
    end else begin
      case (state)
        SNAP_IDLE: begin
          if (frame_start) begin
            state <= SNAP_SCAN;
            busy  <= 1'b1;
            k     <= '0;
          end
        end
        SNAP_SCAN: begin
          // A request on the completion edge is still an overrun, never a restart.
          if (frame_start) overrun <= 1'b1;
          k <= k + ADDR_W'(1);
          if (last) begin
            state      <= SNAP_IDLE;
            busy       <= 1'b0;
            snap_valid <= 1'b1;
            k          <= '0;
`ifdef SM_SNAPSHOT_DBLBUF_EN
            bank_sel   <= ~bank_sel;
`endif
          end
        end
        default: state <= SNAP_IDLE;
      endcase
    end
  end

  // Until a full snapshot exists the store may hold stale or partial data, so the read is forced to 0.
  sm_snapshot_ram #(
    .DEPTH  (1 << RAM_AW),
    .AW     (RAM_AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (cpu_data),
    .raddr  (raddr),
    .rd_clr (rst || !snap_valid),
    .rdata  (scr_data)
  );

endmodule

// File: tb/tb_sm_reg_snapshot.sv
// Directed bench for sm_reg_snapshot; screen reads are checked through an expected-value queue.
module tb_sm_reg_snapshot;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_data;
  logic [4:0]  scr_addr;
  logic [31:0] scr_data;
  logic        busy;
  logic        snap_valid;
  logic        overrun;

  logic [31:0] base;
  logic [31:0] exp_q[$];
  logic        rd_req = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign cpu_data = base | {27'd0, cpu_addr};

  sm_reg_snapshot dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .scr_addr    (scr_addr),
    .scr_data    (scr_data),
    .busy        (busy),
    .snap_valid  (snap_valid),
    .overrun     (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one screen address for one cycle and queue the value it must return.
  task automatic rd(input logic [4:0] a, input logic [31:0] e);
    scr_addr = a;
    rd_req   = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  // Pulse frame_start for one edge T; returns at the negedge after T.
  task automatic start_scan();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Monitor: a read accepted at an edge must show its data just after that edge.
  always @(posedge clk) begin
    if (rd_req) begin
      logic [31:0] e;
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scr_data: got %h with no expected entry queued", scr_data);
      end else begin
        e = exp_q.pop_front();
        if (scr_data !== e) begin
          n_fail++;
          $display("FAIL scr_data: got %h expected %h at %0t", scr_data, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  a;
    logic [31:0] e;
    rst = 1'b1; frame_start = 1'b0; scr_addr = '0; base = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_snap_valid", {31'd0, snap_valid}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_cpu_addr", {27'd0, cpu_addr}, 32'd0);
    chk("reset_scr_data", scr_data, 32'd0);
    rd(5'd5, 32'd0);
    chk("pre_snap_valid", {31'd0, snap_valid}, 32'd0);

    // First scan: busy for exactly 32 cycles, cpu_addr steps 0..31.
    base = 32'hA000_0000;
    start_scan();
    for (int i = 0; i < 32; i++) begin
      chk("scan1_busy", {31'd0, busy}, 32'd1);
      chk("scan1_cpu_addr", {27'd0, cpu_addr}, i);
      @(negedge clk);
    end
    chk("scan1_busy_fall", {31'd0, busy}, 32'd0);
    chk("scan1_snap_valid", {31'd0, snap_valid}, 32'd1);
    chk("scan1_cpu_addr_end", {27'd0, cpu_addr}, 32'd0);
    rd(5'd31, 32'hA000_001F);
    for (int i = 0; i < 4; i++) rd(5'(i), 32'hA000_0000 + i);

    // Second scan with new model values, reading during the scan and across the swap.
    base = 32'hB000_0000;
    start_scan();
    for (int i = 0; i < 34; i++) begin
      a = 5'(31 - i);
`ifdef SM_SNAPSHOT_DBLBUF_EN
      e = (i < 32) ? (32'hA000_0000 | a) : (32'hB000_0000 | a);
`else
      e = (i > int'(a) || i >= 32) ? (32'hB000_0000 | a) : (32'hA000_0000 | a);
`endif
      rd(a, e);
    end
    chk("scan2_idle", {31'd0, busy}, 32'd0);

    // Overrun: extra requests at T+10 and on the completion edge T+32.
    base = 32'hC000_0000;
    start_scan();
    for (int j = 0; j < 35; j++) begin
      if (j == 0)  chk("ovr_clear_before", {31'd0, overrun}, 32'd0);
      if (j == 10) chk("ovr_set", {31'd0, overrun}, 32'd1);
      chk("ovr_busy", {31'd0, busy}, (j <= 31) ? 32'd1 : 32'd0);
      frame_start = (j == 9 || j == 31);
      @(negedge clk);
    end
    frame_start = 1'b0;
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    rd(5'd7, 32'hC000_0007);

    // Reset in the middle of a scan, then a clean full scan.
    base = 32'hD000_0000;
    start_scan();
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_snap_valid", {31'd0, snap_valid}, 32'd0);
    chk("mid_rst_cpu_addr", {27'd0, cpu_addr}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    rd(5'd3, 32'd0);
    start_scan();
    for (int i = 0; i < 32; i++) begin
      chk("scan3_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    chk("scan3_busy_fall", {31'd0, busy}, 32'd0);
    chk("scan3_snap_valid", {31'd0, snap_valid}, 32'd1);
    rd(5'd2, 32'hD000_0002);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
